// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// variable-latency memory handshake with timeout trap, retired-instruction count.
module riscv_mc_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             JalrSel,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [1:0]       RWSel,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam bit              TO_EN   = (MEM_TIMEOUT > 0);
    localparam int              TO_L_I  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_L_I);

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             legal, waiting, timeout;
    logic             is_r, is_i, is_ld, is_st, is_br;
    logic             is_jal, is_jalr, is_lui, is_auipc;

    always_comb begin
        unique case (opcode)
            OP_R, OP_I, OP_LD, OP_ST, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    assign is_r     = (op_q == OP_R);
    assign is_i     = (op_q == OP_I);
    assign is_ld    = (op_q == OP_LD);
    assign is_st    = (op_q == OP_ST);
    assign is_br    = (op_q == OP_BR);
    assign is_jal   = (op_q == OP_JAL);
    assign is_jalr  = (op_q == OP_JALR);
    assign is_lui   = (op_q == OP_LUI);
    assign is_auipc = (op_q == OP_AUIPC);

    assign waiting = mem_req && !mem_ready;
    // The MEM_TIMEOUT-th consecutive stalled cycle is the one that traps.
    assign timeout = TO_EN && waiting && (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        instret_d = instret_q;
        cnt_d     = waiting ? cnt_q + TO_W'(1) : cnt_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_br) begin
                    state_d   = S_FETCH;
                    instret_d = instret_q + CNT_W'(1);
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready && is_ld) begin
                    state_d = S_WB;
                end else if (mem_ready) begin
                    state_d   = S_FETCH;
                    instret_d = instret_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                instret_d = instret_q + CNT_W'(1);
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_TRAP;
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        JalrSel  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        ALUop    = 2'b00;
        RWSel    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b10;
                IRWrite = mem_ready && reset;
                PCWrite = mem_ready && reset;
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_r:  begin ALUSrcA = 2'b01; ALUop = 2'b10; end
                    is_i:  begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; ALUop = 2'b11; end
                    is_ld, is_st: begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
                    is_br: begin ALUSrcA = 2'b01; ALUop = 2'b01; Branch = 1'b1; end
                    is_jal: begin ALUSrcB = 2'b01; PCWrite = 1'b1; end
                    is_jalr: begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b01;
                        PCWrite = 1'b1;
                        JalrSel = 1'b1;
                    end
                    is_auipc: ALUSrcB = 2'b01;
                    is_lui: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemRead  = is_ld;
                MemWrite = is_st;
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b01;
            end
            S_WB: begin
                RegWrite = 1'b1;
                unique case (1'b1)
                    is_ld:             RWSel = 2'b01;
                    is_jal, is_jalr:   RWSel = 2'b10;
                    is_lui:            RWSel = 2'b11;
                    default:           RWSel = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    assign trap    = (state_q == S_TRAP);
    assign instret = instret_q;

endmodule
